// File: rtl/reg_bank.sv
// Parametrised register bank: one load/increment/clear write port and two registered read ports.
// Optional build macro REG_BANK_BYPASS_EN forwards a same-cycle write result to a colliding read.
module reg_bank #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [1:0]       wr_op,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             rd_valid,
    output logic             inc_ovf,
    output logic             addr_err
);

    typedef enum logic [1:0] {
        OP_HOLD  = 2'b00,
        OP_LOAD  = 2'b01,
        OP_INC   = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

`ifdef REG_BANK_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [WIDTH-1:0] regs [DEPTH];

    op_e              wr_kind;
    logic [WIDTH-1:0] old_wr;
    logic [WIDTH-1:0] old_a;
    logic [WIDTH-1:0] old_b;
    logic [WIDTH-1:0] new_val;
    logic             wr_ok;
    logic             ra_ok;
    logic             rb_ok;
    logic             wr_hit;
    logic             wraps;
    logic             bad_access;
    logic [WIDTH-1:0] next_a;
    logic [WIDTH-1:0] next_b;

    assign wr_kind = op_e'(wr_op);

    // DEPTH need not be a power of two, so entries are selected by scanning
    // rather than indexing, which keeps unused address codes harmless.
    always_comb begin
        old_wr = '0;
        old_a  = '0;
        old_b  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (int'(wr_addr) == i) old_wr = regs[i];
            if (int'(rd_addr_a) == i) old_a = regs[i];
            if (int'(rd_addr_b) == i) old_b = regs[i];
        end
    end

    always_comb begin
        wr_ok  = int'(wr_addr) < DEPTH;
        ra_ok  = int'(rd_addr_a) < DEPTH;
        rb_ok  = int'(rd_addr_b) < DEPTH;
        wr_hit = wr_en && wr_ok;

        case (wr_kind)
            OP_LOAD:  new_val = wr_data;
            OP_INC:   new_val = old_wr + WIDTH'(1);
            OP_CLEAR: new_val = '0;
            default:  new_val = old_wr;
        endcase

        wraps      = wr_hit && (wr_kind == OP_INC) && (&old_wr);
        bad_access = (wr_en && !wr_ok) || (rd_en && (!ra_ok || !rb_ok));
    end

    // Read data selection: out-of-range reads return zero, collisions forward only in bypass builds.
    always_comb begin
        next_a = '0;
        next_b = '0;
        if (ra_ok) begin
            if (BYPASS && wr_hit && (rd_addr_a == wr_addr)) next_a = new_val;
            else                                             next_a = old_a;
        end
        if (rb_ok) begin
            if (BYPASS && wr_hit && (rd_addr_b == wr_addr)) next_b = new_val;
            else                                             next_b = old_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (wr_hit) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (int'(wr_addr) == i) regs[i] <= new_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_a <= '0;
            rd_data_b <= '0;
            rd_valid  <= 1'b0;
            inc_ovf   <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            inc_ovf  <= wraps;
            addr_err <= bad_access;
            if (rd_en) begin
                rd_data_a <= next_a;
                rd_data_b <= next_b;
            end
        end
    end

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank (WIDTH=8, DEPTH=6, AW=3): directed vector table then
// randomized traffic against a behavioural model; honours REG_BANK_BYPASS_EN when defined.
module tb_reg_bank;

    localparam int WIDTH = 8;
    localparam int DEPTH = 6;
    localparam int AW    = 3;

`ifdef REG_BANK_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic       rst;
        logic       wr_en;
        logic [1:0] wr_op;
        logic [2:0] wr_addr;
        logic [7:0] wr_data;
        logic       rd_en;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
        logic       exp_valid;
        logic       exp_ovf;
        logic       exp_err;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_en;
    logic [1:0]       wr_op;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [AW-1:0]    rd_addr_a;
    logic [AW-1:0]    rd_addr_b;
    logic [WIDTH-1:0] rd_data_a;
    logic [WIDTH-1:0] rd_data_b;
    logic             rd_valid;
    logic             inc_ovf;
    logic             addr_err;

    int checks   = 0;
    int failures = 0;

    logic [7:0] m_regs [DEPTH];
    logic [7:0] m_a;
    logic [7:0] m_b;
    logic       m_valid;
    logic       m_ovf;
    logic       m_err;

    vec_t vecs[$];

    reg_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_op     (wr_op),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .rd_valid  (rd_valid),
        .inc_ovf   (inc_ovf),
        .addr_err  (addr_err)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic we, input logic [1:0] op, input int wa,
                                input logic [7:0] wd, input logic re, input int ra, input int rb,
                                input logic [7:0] ea, input logic [7:0] eb, input logic ev,
                                input logic eo, input logic ee);
        vec_t v;
        v.rst = r;   v.wr_en = we; v.wr_op = op; v.wr_addr = 3'(wa); v.wr_data = wd;
        v.rd_en = re; v.ra = 3'(ra); v.rb = 3'(rb);
        v.exp_a = ea; v.exp_b = eb; v.exp_valid = ev; v.exp_ovf = eo; v.exp_err = ee;
        return v;
    endfunction

    // Behavioural model: what the bank should show after one clock edge with these inputs.
    task automatic modelStep(input vec_t v);
        logic [7:0] pre  [DEPTH];
        logic [7:0] post [DEPTH];
        int wa, ra, rb;
        wa = int'(v.wr_addr); ra = int'(v.ra); rb = int'(v.rb);
        if (v.rst) begin
            for (int i = 0; i < DEPTH; i++) m_regs[i] = 8'h00;
            m_a = 0; m_b = 0; m_valid = 0; m_ovf = 0; m_err = 0;
            return;
        end
        pre  = m_regs;
        post = m_regs;
        m_ovf = 1'b0;
        m_err = (v.wr_en && wa >= DEPTH) || (v.rd_en && (ra >= DEPTH || rb >= DEPTH));
        if (v.wr_en && wa < DEPTH) begin
            case (v.wr_op)
                2'b01: post[wa] = v.wr_data;
                2'b10: begin post[wa] = 8'((int'(pre[wa]) + 1) % 256); m_ovf = (pre[wa] == 8'd255); end
                2'b11: post[wa] = 8'h00;
                default: ;
            endcase
        end
        m_valid = v.rd_en;
        if (v.rd_en) begin
            m_a = (ra >= DEPTH) ? 8'h00 : (BYP ? post[ra] : pre[ra]);
            m_b = (rb >= DEPTH) ? 8'h00 : (BYP ? post[rb] : pre[rb]);
        end
        m_regs = post;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%h required=0x%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst = v.rst; wr_en = v.wr_en; wr_op = v.wr_op; wr_addr = v.wr_addr; wr_data = v.wr_data;
        rd_en = v.rd_en; rd_addr_a = v.ra; rd_addr_b = v.rb;
        @(posedge clk);
        modelStep(v);
        #1;
    endtask

    initial begin
        rst = 1'b1; wr_en = 0; wr_op = 0; wr_addr = 0; wr_data = 0;
        rd_en = 0; rd_addr_a = 0; rd_addr_b = 0;
        for (int i = 0; i < DEPTH; i++) m_regs[i] = 8'h00;
        m_a = 0; m_b = 0; m_valid = 0; m_ovf = 0; m_err = 0;

        //           rst we op     wa wd     re ra rb  exp_a                exp_b  v  o  e
        vecs.push_back(mk(1, 0, 2'b00, 0, 8'h00, 1, 0, 7, 8'h00,               8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 0, 2'b00, 0, 8'h00, 1, 0, 5, 8'h00,               8'h00, 1, 0, 0));
        vecs.push_back(mk(0, 1, 2'b01, 1, 8'h05, 0, 0, 0, 8'h00,               8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 1, 2'b01, 5, 8'hA5, 0, 0, 0, 8'h00,               8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 0, 2'b00, 0, 8'h00, 1, 1, 5, 8'h05,               8'hA5, 1, 0, 0));
        vecs.push_back(mk(0, 0, 2'b00, 0, 8'h00, 0, 0, 0, 8'h05,               8'hA5, 0, 0, 0));
        vecs.push_back(mk(0, 1, 2'b01, 3, 8'hFE, 0, 0, 0, 8'h05,               8'hA5, 0, 0, 0));
        vecs.push_back(mk(0, 1, 2'b10, 3, 8'h00, 0, 0, 0, 8'h05,               8'hA5, 0, 0, 0));
        vecs.push_back(mk(0, 1, 2'b10, 3, 8'h00, 0, 0, 0, 8'h05,               8'hA5, 0, 1, 0));
        vecs.push_back(mk(0, 0, 2'b00, 0, 8'h00, 0, 0, 0, 8'h05,               8'hA5, 0, 0, 0));
        vecs.push_back(mk(0, 0, 2'b00, 0, 8'h00, 1, 3, 3, 8'h00,               8'h00, 1, 0, 0));
        vecs.push_back(mk(0, 1, 2'b01, 2, 8'h11, 0, 0, 0, 8'h00,               8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 1, 2'b01, 2, 8'h22, 1, 2, 1, BYP ? 8'h22 : 8'h11, 8'h05, 1, 0, 0));
        vecs.push_back(mk(0, 0, 2'b00, 0, 8'h00, 1, 2, 2, 8'h22,               8'h22, 1, 0, 0));
        vecs.push_back(mk(0, 1, 2'b01, 6, 8'h33, 0, 0, 0, 8'h22,               8'h22, 0, 0, 1));
        vecs.push_back(mk(0, 0, 2'b00, 0, 8'h00, 1, 0, 7, 8'h00,               8'h00, 1, 0, 1));
        vecs.push_back(mk(0, 0, 2'b00, 0, 8'h00, 1, 2, 5, 8'h22,               8'hA5, 1, 0, 0));
        vecs.push_back(mk(0, 0, 2'b01, 5, 8'hFF, 0, 0, 0, 8'h22,               8'hA5, 0, 0, 0));
        vecs.push_back(mk(0, 0, 2'b00, 0, 8'h00, 1, 5, 2, 8'hA5,               8'h22, 1, 0, 0));
        vecs.push_back(mk(0, 1, 2'b01, 4, 8'h44, 0, 0, 0, 8'hA5,               8'h22, 0, 0, 0));
        vecs.push_back(mk(1, 1, 2'b11, 4, 8'h00, 1, 4, 4, 8'h00,               8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 0, 2'b00, 0, 8'h00, 1, 4, 1, 8'h00,               8'h00, 1, 0, 0));
        vecs.push_back(mk(0, 0, 2'b00, 0, 8'h00, 1, 5, 3, 8'h00,               8'h00, 1, 0, 0));
        vecs.push_back(mk(0, 1, 2'b01, 0, 8'h77, 0, 0, 0, 8'h00,               8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 1, 2'b11, 0, 8'h00, 1, 0, 0, BYP ? 8'h00 : 8'h77, BYP ? 8'h00 : 8'h77, 1, 0, 0));
        vecs.push_back(mk(0, 0, 2'b00, 0, 8'h00, 1, 0, 0, 8'h00,               8'h00, 1, 0, 0));
        vecs.push_back(mk(0, 1, 2'b10, 5, 8'h00, 1, 5, 2, BYP ? 8'h01 : 8'h00, 8'h00, 1, 0, 0));

        for (int k = 0; k < vecs.size(); k++) begin
            applyStimulus(vecs[k]);
            checkOutput($sformatf("vec%0d_rd_data_a", k), rd_data_a, vecs[k].exp_a);
            checkOutput($sformatf("vec%0d_rd_data_b", k), rd_data_b, vecs[k].exp_b);
            checkOutput($sformatf("vec%0d_rd_valid", k), 8'(rd_valid), 8'(vecs[k].exp_valid));
            checkOutput($sformatf("vec%0d_inc_ovf", k), 8'(inc_ovf), 8'(vecs[k].exp_ovf));
            checkOutput($sformatf("vec%0d_addr_err", k), 8'(addr_err), 8'(vecs[k].exp_err));
        end

        // Random traffic; registers are seeded near all-ones now and then so wraps actually occur.
        for (int n = 0; n < 400; n++) begin
            vec_t v;
            v = mk(($urandom_range(0, 59) == 0), $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                   $urandom_range(0, 7), ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom),
                   $urandom_range(0, 2) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                   8'h00, 8'h00, 0, 0, 0);
            applyStimulus(v);
            checkOutput($sformatf("rand%0d_rd_data_a", n), rd_data_a, m_a);
            checkOutput($sformatf("rand%0d_rd_data_b", n), rd_data_b, m_b);
            checkOutput($sformatf("rand%0d_rd_valid", n), 8'(rd_valid), 8'(m_valid));
            checkOutput($sformatf("rand%0d_inc_ovf", n), 8'(inc_ovf), 8'(m_ovf));
            checkOutput($sformatf("rand%0d_addr_err", n), 8'(addr_err), 8'(m_err));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_bank.md
# reg_bank

Parametrised multi-entry register bank; the successor to the single 8-bit enabled register in the processor datapath. It holds DEPTH registers of WIDTH bits and provides one write port with an operation select (load / increment / clear) and two registered read ports. It sits between the decoder and the ALU and serves as the processor's general register storage.

## Interface
- WIDTH, 8, data width of each register (≥2)
- DEPTH, 8, number of registers (2..256, need not be a power of two)
- AW, 3, address width; must satisfy 2^AW ≥ DEPTH
- clk  input  1  rising-edge clock, single domain
- rst  input  1  synchronous, active-high reset
- wr_en  input  1  write-port strobe; the operation executes on this cycle's rising edge
- wr_op  input  2  00 = hold, 01 = load wr_data, 10 = increment, 11 = clear
- wr_addr  input  AW  target register
- wr_data  input  WIDTH  load value (used only for op 01)
- rd_en  input  1  read strobe for both ports
- rd_addr_a  input  AW  port A address
- rd_addr_b  input  AW  port B address
- rd_data_a  output  WIDTH  registered port A data
- rd_data_b  output  WIDTH  registered port B data
- rd_valid  output  1  high for one cycle when rd_data_* update from an rd_en
- inc_ovf  output  1  one-cycle pulse when an increment wraps from all-ones to zero
- addr_err  output  1  one-cycle pulse when any enabled access uses an address ≥ DEPTH

## Operation
- Reset (rst=1 at an edge): all registers, rd_data_a, rd_data_b, rd_valid, inc_ovf and addr_err are set to 0. Reset overrides wr_en and rd_en in the same cycle.
- Write port, when wr_en=1 and wr_addr<DEPTH:
  - 00: register unchanged
  - 01: reg ← wr_data
  - 10: reg ← reg+1 modulo 2^WIDTH; inc_ovf=1 next cycle if the old value was all-ones
  - 11: reg ← 0
- wr_en=0: no register changes. wr_op is ignored.
- Read: when rd_en=1, rd_data_a and rd_data_b capture the addressed registers and rd_valid=1 next cycle. When rd_en=0, rd_data_* hold their previous values and rd_valid=0.
- Both read ports may address the same register; both return the same value.
- Out-of-range address (≥ DEPTH):
  - a write is dropped
  - a read returns 0 on that port
  - addr_err pulses for one cycle (one pulse even if several ports are bad)
- inc_ovf and addr_err are pulses, not sticky.

## Timing
- Write latency: the register value is updated at the edge where wr_en is sampled and is visible to a read issued on the next cycle.
- Read latency: 1 cycle from rd_en to rd_data_*/rd_valid.
- Back-to-back reads every cycle are supported; rd_valid stays high continuously.
- Same-cycle read and write to the same address: the result depends on REG_BANK_BYPASS_EN (see Configuration).
- Reset mid-stream: a read in flight is cancelled. rd_valid=0 and rd_data_*=0 on the cycle after the reset edge.

## Configuration
- REG_BANK_BYPASS_EN defined: on a same-cycle write and read of the same valid address, the read port returns the post-operation value. Examples: the loaded value, old+1 for increment, 0 for clear.
- REG_BANK_BYPASS_EN undefined: the read returns the pre-write value. The new value is visible from the next read onward.
- All other behaviour is identical in both builds.

## Test plan
- Reset then read: rst=1 for 1 cycle; read addresses 0 and 7 → rd_data_a=rd_data_b=0, inc_ovf=0, addr_err=0.
- Load/readback (WIDTH=8, DEPTH=8):
  - load 0x05 to r1 and 0xA5 to r7
  - next cycle read A=1, B=7 → rd_data_a=0x05, rd_data_b=0xA5, rd_valid=1 for one cycle
- Increment wrap:
  - load 0xFE to r3, then increment twice
  - first increment → r3=0xFF, no pulse
  - second increment → r3=0x00 and inc_ovf=1 for exactly one cycle
- Collision (r2=0x11, same cycle load 0x22 to r2 and read A=2):
  - with REG_BANK_BYPASS_EN → rd_data_a=0x22
  - without → rd_data_a=0x11, and the following read returns 0x22
- Bounds (DEPTH=6, AW=3):
  - write 0x33 to addr 6 → addr_err pulse and no register changes
  - read B=7 → rd_data_b=0 and addr_err pulse
- Reset mid-operation: after loading r4=0x44, assert rst together with rd_en and wr_en (clear r4) → next cycle rd_valid=0, rd_data_*=0, and all registers read back as 0.
